// File: rtl/ras_ckpt_stack.sv
// Circular return-address stack with multi-slot checkpoint/restore for call/return prediction.
// Optional overflow/underflow statistics counters are enabled by defining RAS_STATS_EN.
module ras_ckpt_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned NCKPT = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned IW = (NCKPT > 1) ? $clog2(NCKPT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_addr,
  output logic [WIDTH-1:0] top_addr,
  output logic             empty,
  output logic             full,
  input  logic             ckpt_save,
  input  logic [IW-1:0]    ckpt_save_id,
  input  logic             ckpt_restore,
  input  logic [IW-1:0]    ckpt_rest_id
`ifdef RAS_STATS_EN
  ,
  output logic [15:0]      ovf_cnt,
  output logic [15:0]      unf_cnt
`endif
);

  typedef struct packed {
    logic [PW-1:0]    tos;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] top_val;
  } ckpt_t;

  logic [PW-1:0]    tos_q, tos_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] entry_q [DEPTH];
  ckpt_t            slot_q [NCKPT];
  ckpt_t            rest_slot;
  ckpt_t            save_val;
  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(DEPTH));
  assign top_addr  = empty ? '0 : entry_q[tos_q];
  assign rest_slot = slot_q[ckpt_rest_id];

  // Next pointer/count and single entry write; restore overrides push/pop.
  always_comb begin
    tos_d   = tos_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = tos_q;
    wr_data = push_addr;
    if (ckpt_restore) begin
      tos_d   = rest_slot.tos;
      cnt_d   = rest_slot.cnt;
      wr_en   = 1'b1;
      wr_idx  = rest_slot.tos;
      wr_data = rest_slot.top_val;
    end else if (push && pop && !empty) begin
      wr_en = 1'b1;
    end else if (push) begin
      tos_d  = tos_q + PW'(1);
      cnt_d  = full ? cnt_q : cnt_q + CW'(1);
      wr_en  = 1'b1;
      wr_idx = tos_q + PW'(1);
    end else if (pop && !empty) begin
      tos_d = tos_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  // A save alongside a restore captures the state being restored.
  always_comb begin
    save_val.tos     = tos_q;
    save_val.cnt     = cnt_q;
    save_val.top_val = entry_q[tos_q];
    if (ckpt_restore) begin
      save_val = rest_slot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      for (int j = 0; j < NCKPT; j++) slot_q[j] <= '0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      if (wr_en) entry_q[wr_idx] <= wr_data;
      if (ckpt_save) slot_q[ckpt_save_id] <= save_val;
    end
  end

`ifdef RAS_STATS_EN
  // Saturating event counters; a restore cycle performs no push/pop so counts nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else begin
      if (!ckpt_restore && push && !pop && full && (ovf_cnt != 16'hFFFF))
        ovf_cnt <= ovf_cnt + 16'd1;
      if (!ckpt_restore && pop && !push && empty && (unf_cnt != 16'hFFFF))
        unf_cnt <= unf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Self-checking bench for ras_ckpt_stack: directed scenarios plus randomized traffic
// checked against a behavioural array model of the stack and checkpoint slots.
module tb_ras_ckpt_stack;
  localparam int DEPTH = 8;
  localparam int NCKPT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push, pop, ckpt_save, ckpt_restore;
  logic [31:0] push_addr, top_addr;
  logic        empty, full;
  logic [1:0]  ckpt_save_id, ckpt_rest_id;
`ifdef RAS_STATS_EN
  logic [15:0] ovf_cnt, unf_cnt;
`endif

  ras_ckpt_stack #(.WIDTH(32), .DEPTH(DEPTH), .NCKPT(NCKPT)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .push_addr(push_addr),
    .top_addr(top_addr), .empty(empty), .full(full),
    .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
    .ckpt_restore(ckpt_restore), .ckpt_rest_id(ckpt_rest_id)
`ifdef RAS_STATS_EN
    , .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: plain integer ring buffer plus snapshot arrays.
  int          m_tos, m_cnt, m_ovf, m_unf;
  logic [31:0] m_ent [DEPTH];
  int          s_tos [NCKPT];
  int          s_cnt [NCKPT];
  logic [31:0] s_top [NCKPT];
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic model_reset();
    m_tos = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
    for (int i = 0; i < DEPTH; i++) m_ent[i] = '0;
    for (int i = 0; i < NCKPT; i++) begin s_tos[i] = 0; s_cnt[i] = 0; s_top[i] = '0; end
  endtask

  task automatic model_step(input bit pu, input bit po, input logic [31:0] a,
                            input bit sv, input int sid, input bit rs, input int rid);
    int st, sc;
    logic [31:0] stv;
    if (rs) begin st = s_tos[rid]; sc = s_cnt[rid]; stv = s_top[rid]; end
    else begin st = m_tos; sc = m_cnt; stv = m_ent[m_tos]; end
    if (rs) begin
      m_tos = s_tos[rid]; m_cnt = s_cnt[rid]; m_ent[m_tos] = s_top[rid];
    end else if (pu && po && m_cnt > 0) begin
      m_ent[m_tos] = a;
    end else if (pu) begin
      if (po == 0 && m_cnt == DEPTH && m_ovf < 65535) m_ovf++;
      m_tos = (m_tos + 1) % DEPTH;
      m_ent[m_tos] = a;
      if (m_cnt < DEPTH) m_cnt++;
    end else if (po) begin
      if (m_cnt > 0) begin m_tos = (m_tos + DEPTH - 1) % DEPTH; m_cnt--; end
      else if (m_unf < 65535) m_unf++;
    end
    if (sv) begin s_tos[sid] = st; s_cnt[sid] = sc; s_top[sid] = stv; end
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_model(input string tag);
    cmp({tag, ".top"}, top_addr, (m_cnt == 0) ? 32'h0 : m_ent[m_tos]);
    cmp({tag, ".empty"}, 32'(empty), 32'(m_cnt == 0));
    cmp({tag, ".full"}, 32'(full), 32'(m_cnt == DEPTH));
`ifdef RAS_STATS_EN
    cmp({tag, ".ovf"}, 32'(ovf_cnt), 32'(m_ovf));
    cmp({tag, ".unf"}, 32'(unf_cnt), 32'(m_unf));
`endif
  endtask

  task automatic step(input string tag, input bit pu, input bit po, input logic [31:0] a,
                      input bit sv, input int sid, input bit rs, input int rid);
    push = pu; pop = po; push_addr = a;
    ckpt_save = sv; ckpt_save_id = 2'(sid); ckpt_restore = rs; ckpt_rest_id = 2'(rid);
    @(posedge clk);
    model_step(pu, po, a, sv, sid, rs, rid);
    #1;
    push = 1'b0; pop = 1'b0; ckpt_save = 1'b0; ckpt_restore = 1'b0;
    check_model(tag);
  endtask

  task automatic do_push(input logic [31:0] a); step("push", 1, 0, a, 0, 0, 0, 0); endtask
  task automatic do_pop();                     step("pop", 0, 1, 0, 0, 0, 0, 0); endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_model("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    push = 0; pop = 0; push_addr = 0; ckpt_save = 0; ckpt_restore = 0;
    ckpt_save_id = 0; ckpt_rest_id = 0;
    rst_n = 1'b0;
    #2;
    model_reset();
    cmp("reset.top", top_addr, 32'h0);
    cmp("reset.empty", 32'(empty), 32'h1);
    cmp("reset.full", 32'(full), 32'h0);
    do_reset();

    // T1 basic push/pop
    do_push(32'h100); cmp("t1.top0", top_addr, 32'h100);
    do_push(32'h200); cmp("t1.top1", top_addr, 32'h200);
    do_pop();         cmp("t1.top2", top_addr, 32'h100); cmp("t1.empty2", 32'(empty), 32'h0);
    do_pop();         cmp("t1.top3", top_addr, 32'h0);   cmp("t1.empty3", 32'(empty), 32'h1);

    // T2 overflow then drain with one underflow
    for (int i = 1; i <= 9; i++) do_push(32'(i * 16));
    cmp("t2.full", 32'(full), 32'h1); cmp("t2.top", top_addr, 32'h90);
    for (int i = 9; i >= 2; i--) begin
      cmp("t2.drain", top_addr, 32'(i * 16));
      do_pop();
    end
    cmp("t2.empty", 32'(empty), 32'h1);
    do_pop();
    cmp("t2.unf_top", top_addr, 32'h0); cmp("t2.unf_empty", 32'(empty), 32'h1);
`ifdef RAS_STATS_EN
    cmp("t2.ovf_cnt", 32'(ovf_cnt), 32'h1); cmp("t2.unf_cnt", 32'(unf_cnt), 32'h1);
`endif

    // T3 replace-top and push&pop on empty
    do_push(32'hA0);
    step("t3.rep", 1, 1, 32'hB0, 0, 0, 0, 0); cmp("t3.top_b0", top_addr, 32'hB0);
    do_pop(); cmp("t3.cnt1", 32'(empty), 32'h1);
    step("t3.emp", 1, 1, 32'hC0, 0, 0, 0, 0); cmp("t3.top_c0", top_addr, 32'hC0);
    do_pop(); cmp("t3.cnt1b", 32'(empty), 32'h1);

    // T4 checkpoint repair of pointer and overwritten top
    do_push(32'h400); do_push(32'h500);
    step("t4.save", 0, 0, 0, 1, 2, 0, 0);
    do_pop(); do_push(32'h999); cmp("t4.dirty", top_addr, 32'h999);
    step("t4.rest", 0, 0, 0, 0, 0, 1, 2); cmp("t4.top", top_addr, 32'h500);
    do_pop(); cmp("t4.below", top_addr, 32'h400);

    // T5 restore beats push; save&restore same id leaves slot intact
    step("t5.prio", 1, 0, 32'h777, 0, 0, 1, 2); cmp("t5.top", top_addr, 32'h500);
    do_pop(); do_pop(); cmp("t5.empty", 32'(empty), 32'h1);
    step("t5.same", 0, 0, 0, 1, 2, 1, 2); cmp("t5.same_top", top_addr, 32'h500);
    do_push(32'h123);
    step("t5.again", 0, 0, 0, 0, 0, 1, 2); cmp("t5.slot", top_addr, 32'h500);

    // T6 async reset between edges
    for (int i = 0; i < 5; i++) do_push(32'h1000 + 32'(i));
    cmp("t6.pre", top_addr, 32'h1004);
    #2 rst_n = 1'b0;
    #1;
    cmp("t6.top", top_addr, 32'h0);
    cmp("t6.empty", 32'(empty), 32'h1);
    cmp("t6.full", 32'(full), 32'h0);
    do_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
           $urandom_range(0, 3) == 0, int'($urandom_range(0, NCKPT - 1)),
           $urandom_range(0, 7) == 0, int'($urandom_range(0, NCKPT - 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
